// File: rtl/countdown_timer_mmss_pkg.sv
// Shared definitions for the MM:SS countdown timer: state encoding,
// time limits and the small arithmetic helpers used by the datapath.
package countdown_timer_mmss_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  // Largest legal value of either field, and the seconds value after a minute borrow.
  localparam logic [5:0] MAX_MMSS  = 6'd59;
  localparam logic [5:0] SEC_RESET = 6'd59;

  typedef struct packed {
    logic [5:0] min;
    logic [5:0] sec;
  } mmss_t;

  // Out-of-range switch presets collapse to zero rather than being saturated.
  function automatic logic [5:0] clamp_preset(input logic [5:0] v);
    logic [5:0] r;
    if (v <= MAX_MMSS) begin
      r = v;
    end else begin
      r = 6'd0;
    end
    return r;
  endfunction

  function automatic logic is_zero(input mmss_t t);
    return (t.min == 6'd0) && (t.sec == 6'd0);
  endfunction

  // One-second decrement with minute borrow; 00:00 stays at 00:00.
  function automatic mmss_t mmss_dec(input mmss_t t);
    mmss_t r;
    r = t;
    if (t.sec != 6'd0) begin
      r.sec = t.sec - 6'd1;
    end else if (t.min != 6'd0) begin
      r.min = t.min - 6'd1;
      r.sec = SEC_RESET;
    end else begin
      r = t;
    end
    return r;
  endfunction

endpackage

// File: rtl/countdown_timer_mmss_sec_tick_gen.sv
// Prescaler producing a one-cycle tick every TICK_DIV enabled clock cycles.
// The count is held (not cleared) while en is low so a paused timer resumes
// mid-second; clr restarts the second from zero.
module sec_tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clock,
  input  logic rst_neg,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = en && !clr && (cnt_q == TERM);

  // Next prescaler value: clear wins, otherwise count and wrap while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = {CW{1'b0}};
    end else if (en) begin
      if (cnt_q == TERM) begin
        cnt_d = {CW{1'b0}};
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Prescaler register with asynchronous clear.
  always_ff @(posedge clock or negedge rst_neg) begin
    if (!rst_neg) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/countdown_timer_mmss.sv
// MM:SS countdown timer: loads a preset from switches, counts down once per
// second while running and raises a timed alarm on reaching 00:00.
module countdown_timer_mmss
  import countdown_timer_mmss_pkg::*;
#(
  parameter int TICK_DIV   = 50_000_000,
  parameter int ALARM_SECS = 5
) (
  input  logic       clock,
  input  logic       rst_neg,
  input  logic       load_neg,
  input  logic       start_stop,
  input  logic [5:0] sw_min,
  input  logic [5:0] sw_sec,
  output logic [5:0] min_q,
  output logic [5:0] sec_q,
  output logic       running,
  output logic       done,
  output logic       alarm
);

  localparam int AW = (ALARM_SECS > 0) ? $clog2(ALARM_SECS + 1) : 1;
  localparam logic [AW-1:0] ALARM_INIT = AW'(ALARM_SECS);

  state_e          state_q, state_d;
  logic [5:0]      min_d, sec_d;
  logic [AW-1:0]   alarm_cnt_q, alarm_cnt_d;
  logic            alarm_q, alarm_d;
  logic            running_q, running_d;
  logic            done_q, done_d;
  logic            load_s;
  logic            tick_s;
  logic            pre_clr_s;
  logic            pre_en_s;
  mmss_t           cur_s;
  mmss_t           dec_s;

  assign load_s   = ~load_neg;
  assign cur_s    = {min_q, sec_q};
  assign dec_s    = mmss_dec(cur_s);
  // The second keeps ticking in DONE so the alarm can be timed in seconds.
  assign pre_en_s = (state_q == ST_RUN) || (state_q == ST_DONE);

  assign running = running_q;
  assign done    = done_q;
  assign alarm   = alarm_q;

  sec_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clock   (clock),
    .rst_neg (rst_neg),
    .clr     (pre_clr_s),
    .en      (pre_en_s),
    .tick    (tick_s)
  );

  // Next-state, time and alarm logic; load has priority over start_stop except in RUN.
  always_comb begin
    state_d     = state_q;
    min_d       = min_q;
    sec_d       = sec_q;
    alarm_cnt_d = alarm_cnt_q;
    alarm_d     = alarm_q;
    pre_clr_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_s) begin
          min_d   = clamp_preset(sw_min);
          sec_d   = clamp_preset(sw_sec);
          state_d = ST_IDLE;
        end else if (start_stop && !is_zero(cur_s)) begin
          state_d   = ST_RUN;
          pre_clr_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (tick_s) begin
          min_d = dec_s.min;
          sec_d = dec_s.sec;
        end else begin
          min_d = min_q;
          sec_d = sec_q;
        end
        if (tick_s && is_zero(dec_s)) begin
          state_d     = ST_DONE;
          alarm_d     = 1'b1;
          alarm_cnt_d = ALARM_INIT;
        end else if (start_stop) begin
          state_d = ST_PAUSE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (load_s) begin
          min_d   = clamp_preset(sw_min);
          sec_d   = clamp_preset(sw_sec);
          state_d = ST_IDLE;
        end else if (start_stop) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_PAUSE;
        end
      end
      ST_DONE: begin
        if (load_s) begin
          min_d       = clamp_preset(sw_min);
          sec_d       = clamp_preset(sw_sec);
          state_d     = ST_IDLE;
          alarm_d     = 1'b0;
          alarm_cnt_d = {AW{1'b0}};
        end else if (start_stop) begin
          state_d     = ST_IDLE;
          alarm_d     = 1'b0;
          alarm_cnt_d = {AW{1'b0}};
        end else if (tick_s && (alarm_cnt_q != {AW{1'b0}})) begin
          alarm_cnt_d = alarm_cnt_q - AW'(1);
          alarm_d     = (alarm_cnt_q != AW'(1));
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        alarm_d     = 1'b0;
        alarm_cnt_d = {AW{1'b0}};
      end
    endcase
    running_d = (state_d == ST_RUN);
    done_d    = (state_d == ST_DONE);
  end

  // State, time and status registers; asynchronous reset clears everything silently.
  always_ff @(posedge clock or negedge rst_neg) begin
    if (!rst_neg) begin
      state_q     <= ST_IDLE;
      min_q       <= 6'd0;
      sec_q       <= 6'd0;
      alarm_cnt_q <= {AW{1'b0}};
      alarm_q     <= 1'b0;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      alarm_cnt_q <= alarm_cnt_d;
      alarm_q     <= alarm_d;
      running_q   <= running_d;
      done_q      <= done_d;
    end
  end

endmodule
